// File: rtl/enc8to3_seq.sv
`default_nettype none
// ============================================================================
//  Module   : enc8to3_seq
//  Purpose  : Sequential 8-to-3 encoder. Captures a register request vector
//             and emits the index of each set bit, one per handshake, in
//             priority order. Feeds the 3-to-8 register-select decoder for
//             multi-register save/restore lists.
//  Options  : ENC_MSB_PRIORITY_EN - when defined, the highest set bit is
//             emitted first (restore order mirrors a save); when undefined,
//             the lowest set bit is emitted first.
//  Revision : 1.0 - initial release
// ============================================================================
module enc8to3_seq (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Load,
  input  logic [7:0] Req,
  output logic [2:0] Y,
  output logic       Valid,
  input  logic       Ready,
  output logic       Busy,
  output logic       Done,
  output logic [3:0] Remaining
);

  // IDLE/EMIT is fully determined by whether any request is still pending,
  // so the state is decoded from the pending vector rather than stored twice.
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  localparam logic [7:0] c_none = 8'h00;

  logic [7:0] r_pending;
  logic       r_done;

  state_t     w_state;
  logic [2:0] w_y;
  logic [7:0] w_sel;
  logic [7:0] w_after;
  logic [3:0] w_count;
  logic [7:0] w_pending_nxt;
  logic       w_done_nxt;

  // Decode the current state from the pending vector.
  always_comb begin
    w_state = (r_pending != c_none) ? ST_EMIT : ST_IDLE;
  end

  // Priority encoder over the pending vector; the last match in loop order wins.
`ifdef ENC_MSB_PRIORITY_EN
  always_comb begin
    w_y = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_pending[i]) begin
        w_y = 3'(i);
      end
    end
  end
`else
  always_comb begin
    w_y = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (r_pending[i]) begin
        w_y = 3'(i);
      end
    end
  end
`endif

  // One-hot mask of the offered index and the vector left after a transfer.
  always_comb begin
    w_sel   = 8'd1 << w_y;
    w_after = r_pending & ~w_sel;
  end

  // Population count of the pending vector (0..8).
  always_comb begin
    w_count = 4'd0;
    for (int i = 0; i < 8; i++) begin
      w_count = w_count + {3'd0, r_pending[i]};
    end
  end

  // Next-state logic: capture in IDLE, retire one index per handshake in EMIT.
  always_comb begin
    w_pending_nxt = r_pending;
    w_done_nxt    = 1'b0;
    case (w_state)
      ST_IDLE: begin
        if (Load) begin
          w_pending_nxt = Req;
          // An empty list completes immediately.
          w_done_nxt    = (Req == c_none);
        end
      end
      ST_EMIT: begin
        // Load is ignored while a list is in flight.
        if (Ready) begin
          w_pending_nxt = w_after;
          w_done_nxt    = (w_after == c_none);
        end
      end
      default: begin
        w_pending_nxt = c_none;
        w_done_nxt    = 1'b0;
      end
    endcase
  end

  // State registers; reset aborts any list without signalling completion.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_pending <= c_none;
      r_done    <= 1'b0;
    end else begin
      r_pending <= w_pending_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // All outputs come from registered state only.
  always_comb begin
    Y         = w_y;
    Valid     = (w_state == ST_EMIT);
    Busy      = (w_state == ST_EMIT);
    Done      = r_done;
    Remaining = w_count;
  end

endmodule
`default_nettype wire

// File: tb/tb_enc8to3_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_enc8to3_seq
//  Purpose  : Self-checking bench for enc8to3_seq. A queue-based model holds
//             the outstanding indices in emission order.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_enc8to3_seq;

  logic       clk;
  logic       Reset;
  logic       Load;
  logic [7:0] Req;
  logic       Ready;
  logic [2:0] Y;
  logic       Valid;
  logic       Busy;
  logic       Done;
  logic [3:0] Remaining;

  int checks   = 0;
  int failures = 0;

  // Model: indices still to be emitted, front = next offered.
  int   m_q[$];
  logic m_done;

  enc8to3_seq dut (
    .Clock     (clk),
    .Reset     (Reset),
    .Load      (Load),
    .Req       (Req),
    .Y         (Y),
    .Valid     (Valid),
    .Ready     (Ready),
    .Busy      (Busy),
    .Done      (Done),
    .Remaining (Remaining)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_all(input string tag);
    logic [2:0] ey;
    logic       ev;
    logic [3:0] er;
    int         front;
    front = (m_q.size() != 0) ? m_q[0] : 0;
    ey    = 3'(front);
    ev    = (m_q.size() != 0);
    er    = 4'(m_q.size());
    checks++;
    assert (Y === ey) else begin
      failures++;
      $error("FAIL %s Y observed=%0d expected=%0d", tag, Y, ey);
    end
    checks++;
    assert (Valid === ev) else begin
      failures++;
      $error("FAIL %s Valid observed=%0b expected=%0b", tag, Valid, ev);
    end
    checks++;
    assert (Busy === ev) else begin
      failures++;
      $error("FAIL %s Busy observed=%0b expected=%0b", tag, Busy, ev);
    end
    checks++;
    assert (Done === m_done) else begin
      failures++;
      $error("FAIL %s Done observed=%0b expected=%0b", tag, Done, m_done);
    end
    checks++;
    assert (Remaining === er) else begin
      failures++;
      $error("FAIL %s Remaining observed=%0d expected=%0d", tag, Remaining, er);
    end
  endtask

  // Apply one cycle of inputs, advance the model, then check after the edge.
  task automatic step(input logic rst, input logic ld, input logic [7:0] rq,
                      input logic rdy, input string tag);
    int idx;
    Reset = rst;
    Load  = ld;
    Req   = rq;
    Ready = rdy;
    if (rst) begin
      m_q.delete();
      m_done = 1'b0;
    end else if (m_q.size() == 0) begin
      m_done = 1'b0;
      if (ld) begin
        for (int k = 0; k < 8; k++) begin
`ifdef ENC_MSB_PRIORITY_EN
          idx = 7 - k;
`else
          idx = k;
`endif
          if (rq[idx]) m_q.push_back(idx);
        end
        m_done = (m_q.size() == 0);
      end
    end else begin
      m_done = 1'b0;
      if (rdy) begin
        void'(m_q.pop_front());
        m_done = (m_q.size() == 0);
      end
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [7:0] rq;
    Reset  = 1'b1;
    Load   = 1'b0;
    Req    = 8'h00;
    Ready  = 1'b0;
    m_done = 1'b0;

    // Reset then idle.
    step(1'b1, 1'b0, 8'h00, 1'b0, "reset0");
    step(1'b1, 1'b1, 8'hFF, 1'b1, "reset1");
    step(1'b0, 1'b0, 8'h00, 1'b0, "idle0");
    step(1'b0, 1'b0, 8'h00, 1'b1, "idle1");

    // Four-entry list drained with Ready held high.
    step(1'b0, 1'b1, 8'b1010_0110, 1'b1, "a6_load");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "a6_drain");
    step(1'b0, 1'b0, 8'h00, 1'b1, "a6_after");

    // Backpressure, with a Load during EMIT that must be ignored.
    step(1'b0, 1'b1, 8'h81, 1'b0, "bp_load");
    step(1'b0, 1'b0, 8'h00, 1'b0, "bp_hold0");
    step(1'b0, 1'b1, 8'h0F, 1'b0, "bp_ignore_load");
    step(1'b0, 1'b0, 8'h00, 1'b1, "bp_take0");
    step(1'b0, 1'b1, 8'h0F, 1'b1, "bp_take1");
    step(1'b0, 1'b0, 8'h00, 1'b0, "bp_after");

    // Empty list completes immediately.
    step(1'b0, 1'b1, 8'h00, 1'b1, "empty_load");
    step(1'b0, 1'b0, 8'h00, 1'b1, "empty_after");

    // Reset mid-operation.
    step(1'b0, 1'b1, 8'hFF, 1'b1, "ff_load");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "ff_take");
    step(1'b1, 1'b0, 8'h00, 1'b1, "ff_reset");
    step(1'b0, 1'b0, 8'h00, 1'b1, "ff_post");

    // Full drain of 8'hFF, then back-to-back load in the Done cycle.
    step(1'b0, 1'b1, 8'hFF, 1'b0, "full_load");
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, "full_drain");
    step(1'b0, 1'b1, 8'h10, 1'b1, "b2b_load");
    step(1'b0, 1'b0, 8'h00, 1'b1, "b2b_take");
    step(1'b0, 1'b0, 8'h00, 1'b1, "b2b_after");

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      case ($urandom_range(0, 7))
        0:       rq = 8'h00;
        1:       rq = 8'hFF;
        default: rq = 8'($urandom);
      endcase
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) == 0), rq,
           ($urandom_range(0, 3) != 0), "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
